// File: rtl/gray_sobel_edge.sv
// -----------------------------------------------------------------------------
// gray_sobel_edge
//
// Streaming 3x3 Sobel edge-magnitude stage for an 8-bit grayscale pixel stream.
// Two previous lines are held in line buffers addressed by column. A 3x3 window
// is formed from those buffers and the incoming pixel. Each accepted pixel
// produces exactly one 8-bit edge-magnitude pixel four cycles later.
//
// Ports:
//   iCLK      in   1  clock, rising edge
//   iReset_n  in   1  asynchronous active-low reset
//   iGray     in   8  gray pixel, sampled when iDval=1
//   iDval     in   1  pixel valid (gaps allowed anywhere)
//   iSOF      in   1  start-of-frame pulse, restarts row/col counters
//   oEdge     out  8  edge magnitude (registered)
//   oDval     out  1  oEdge valid (registered), iDval delayed by 4 cycles
//
// Handshake: there is no backpressure. A pixel is taken on every cycle where
// iDval=1, and oDval=1 marks a result that downstream must consume that cycle.
// -----------------------------------------------------------------------------
module gray_sobel_edge #(
    parameter int LINE_WIDTH   = 800,
    parameter int FRAME_HEIGHT = 480,
    parameter int MAG_SHIFT    = 2
) (
    input  logic       iCLK,
    input  logic       iReset_n,
    input  logic [7:0] iGray,
    input  logic       iDval,
    input  logic       iSOF,
    output logic [7:0] oEdge,
    output logic       oDval
);

    localparam int CW = (LINE_WIDTH   > 1) ? $clog2(LINE_WIDTH)   : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row_next;

    // Position the current input pixel is accepted at. iSOF forces (0,0)
    // for a pixel arriving in the same cycle as the pulse.
    logic [CW-1:0] acc_col;
    logic [RW-1:0] acc_row;
    logic          border;

    always_comb begin
        acc_col  = iSOF ? '0 : col;
        acc_row  = iSOF ? '0 : row;
        col_next = col;
        row_next = row;
        if (iDval) begin
            if (acc_col == COL_LAST) begin
                col_next = '0;
                row_next = (acc_row == ROW_LAST) ? '0 : acc_row + 1'b1;
            end else begin
                col_next = acc_col + 1'b1;
                row_next = acc_row;
            end
        end else if (iSOF) begin
            col_next = '0;
            row_next = '0;
        end
    end

    // The window is not complete until two full lines and two columns of the
    // current line have been seen. This also hides columns that wrapped in
    // from the previous line and stale buffer contents after reset or iSOF.
    assign border = (int'(acc_row) < 2) || (int'(acc_col) < 2);

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds the previous line and lb1 the line before it.
    // The read is combinational, so it returns the pre-write value.
    // Contents are intentionally not reset.
    // ------------------------------------------------------------------
    logic [7:0] lb0 [LINE_WIDTH];
    logic [7:0] lb1 [LINE_WIDTH];
    logic [7:0] lb0_rd;
    logic [7:0] lb1_rd;

    always_comb begin
        lb0_rd = lb0[acc_col];
        lb1_rd = lb1[acc_col];
    end

    always_ff @(posedge iCLK) begin
        if (iDval) begin
            lb1[acc_col] <= lb0_rd;
            lb0[acc_col] <= iGray;
        end
    end

    // ------------------------------------------------------------------
    // S1: window, counters, valid/border tags
    // win[r][k]: r=0 is the top (oldest line), k=0 is the oldest column.
    // ------------------------------------------------------------------
    logic [7:0] win [3][3];
    logic       s1_valid;
    logic       s1_border;

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win[r][k] <= '0;
                end
            end
            col       <= '0;
            row       <= '0;
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
        end else begin
            col      <= col_next;
            row      <= row_next;
            s1_valid <= iDval;
            if (iDval) begin
                s1_border <= border;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_rd;
                win[1][2] <= lb0_rd;
                win[2][2] <= iGray;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: gradients. Each side of a difference is at most 4*255 = 1020, so
    // the 11-bit two's-complement difference cannot overflow. The gradients
    // are kept as plain vectors, and bit 10 is the sign.
    // ------------------------------------------------------------------
    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] gx, gy;
    logic        s2_valid;
    logic        s2_border;

    always_comb begin
        gx_pos = 11'(win[0][2]) + {2'b00, win[1][2], 1'b0} + 11'(win[2][2]);
        gx_neg = 11'(win[0][0]) + {2'b00, win[1][0], 1'b0} + 11'(win[2][0]);
        gy_pos = 11'(win[2][0]) + {2'b00, win[2][1], 1'b0} + 11'(win[2][2]);
        gy_neg = 11'(win[0][0]) + {2'b00, win[0][1], 1'b0} + 11'(win[0][2]);
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            gx        <= '0;
            gy        <= '0;
            s2_valid  <= 1'b0;
            s2_border <= 1'b0;
        end else begin
            gx        <= gx_pos - gx_neg;
            gy        <= gy_pos - gy_neg;
            s2_valid  <= s1_valid;
            s2_border <= s1_border;
        end
    end

    // ------------------------------------------------------------------
    // S3: magnitude |Gx| + |Gy|, at most 2040, so it fits in 11 bits.
    // ------------------------------------------------------------------
    logic [10:0] abs_gx, abs_gy;
    logic [10:0] mag;
    logic        s3_valid;
    logic        s3_border;

    always_comb begin
        abs_gx = gx[10] ? (~gx + 11'd1) : gx;
        abs_gy = gy[10] ? (~gy + 11'd1) : gy;
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            mag       <= '0;
            s3_valid  <= 1'b0;
            s3_border <= 1'b0;
        end else begin
            mag       <= abs_gx + abs_gy;
            s3_valid  <= s2_valid;
            s3_border <= s2_border;
        end
    end

    // ------------------------------------------------------------------
    // S4: scale, saturate, mask the border, register the output
    // ------------------------------------------------------------------
    logic [10:0] scaled;
    logic [7:0]  sat;

    always_comb begin
        scaled = mag >> MAG_SHIFT;
        sat    = (|scaled[10:8]) ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            oEdge <= 8'd0;
            oDval <= 1'b0;
        end else begin
            oEdge <= s3_border ? 8'd0 : sat;
            oDval <= s3_valid;
        end
    end

endmodule

// File: tb/tb_gray_sobel_edge.sv
// -----------------------------------------------------------------------------
// tb_gray_sobel_edge
//
// Two instances share one input stream: one with MAG_SHIFT=2 and one with
// MAG_SHIFT=0. The driver keeps a frame image and a row/col position model,
// and it pushes the expected Sobel result for every accepted pixel. A negedge
// monitor pops the expected values and checks value and latency.
// -----------------------------------------------------------------------------
module tb_gray_sobel_edge;
  localparam int LW = 8;
  localparam int FH = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] gray = 8'd0;
  logic dval = 1'b0;
  logic sof = 1'b0;
  logic [7:0] edge_s2, edge_s0;
  logic dval_s2, dval_s0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gray_sobel_edge #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .MAG_SHIFT(2)) dut (
    .iCLK(clk), .iReset_n(rst_n), .iGray(gray), .iDval(dval), .iSOF(sof),
    .oEdge(edge_s2), .oDval(dval_s2)
  );

  gray_sobel_edge #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .MAG_SHIFT(0)) dut_s0 (
    .iCLK(clk), .iReset_n(rst_n), .iGray(gray), .iDval(dval), .iSOF(sof),
    .oEdge(edge_s0), .oDval(dval_s0)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [7:0] exp2_q[$];
  logic [7:0] exp0_q[$];
  int due_q[$];
  int cnt200 = 0;
  int cnt255 = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: frame image plus a position counter
  int img[FH][LW];
  int m_row = 0;
  int m_col = 0;

  function automatic int ref_edge(input int r, input int c, input int shift);
    int gx, gy, mag, s;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    s = mag >> shift;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic logic [7:0] frame_px(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd200;
      2:       return (r < 3) ? 8'd0 : 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic send(input logic [7:0] px, input logic with_sof);
    int r, c;
    r = with_sof ? 0 : m_row;
    c = with_sof ? 0 : m_col;
    img[r][c] = int'(px);
    exp2_q.push_back(8'(ref_edge(r, c, 2)));
    exp0_q.push_back(8'(ref_edge(r, c, 0)));
    due_q.push_back(cyc + 4);
    m_row = r;
    m_col = c + 1;
    if (m_col == LW) begin
      m_col = 0;
      m_row = (r + 1) % FH;
    end
    gray = px;
    dval = 1'b1;
    sof = with_sof;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic with_sof);
    for (int i = 0; i < n; i++) begin
      gray = 8'($urandom_range(0, 255));
      dval = 1'b0;
      sof = with_sof && (i == 0);
      if (sof) begin
        m_row = 0;
        m_col = 0;
      end
      @(negedge clk);
    end
    sof = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int max_gap, input logic first_sof, input int npix);
    for (int i = 0; i < npix; i++) begin
      send(frame_px(kind, i / LW, i % LW), first_sof && (i == 0));
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)), 1'b0);
    end
    dval = 1'b0;
    sof = 1'b0;
  endtask

  task automatic flush_model();
    exp2_q.delete();
    exp0_q.delete();
    due_q.delete();
    m_row = 0;
    m_col = 0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [7:0] e2, e0;
    int due;
    if (!rst_n) begin
      check("reset_dval", int'({dval_s2, dval_s0}), 0);
      check("reset_edge", int'({edge_s2, edge_s0}), 0);
    end else begin
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        check("missing_output", 0, 1);
        void'(due_q.pop_front());
        void'(exp2_q.pop_front());
        void'(exp0_q.pop_front());
      end
      if (dval_s2 || dval_s0) check("dval_pair", int'(dval_s0), int'(dval_s2));
      if (dval_s2) begin
        if (due_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          due = due_q.pop_front();
          e2 = exp2_q.pop_front();
          e0 = exp0_q.pop_front();
          check("latency", cyc, due);
          check("edge_shift2", int'(edge_s2), int'(e2));
          if (dval_s0) check("edge_shift0", int'(edge_s0), int'(e0));
          if (edge_s2 == 8'd200) cnt200++;
          if (dval_s0 && edge_s0 == 8'd255) cnt255++;
        end
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    // reset with random activity on the inputs
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      gray = 8'($urandom_range(0, 255));
      dval = 1'($urandom_range(0, 1));
      sof = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dval = 1'b0;
    sof = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // flat frame, iSOF alone first
    idle(1, 1'b1);
    send_frame(0, 0, 1'b0, LW*FH);
    idle(6, 1'b0);

    // vertical step
    cnt200 = 0;
    send_frame(1, 0, 1'b1, LW*FH);
    idle(6, 1'b0);
    check("step_200_count", cnt200, 2*(FH-2));

    // saturation (horizontal step, checked on the MAG_SHIFT=0 instance)
    cnt255 = 0;
    send_frame(2, 0, 1'b1, LW*FH);
    idle(6, 1'b0);
    check("sat_255_count", cnt255, 2*(LW-2));

    // gapped vertical step
    cnt200 = 0;
    send_frame(1, 3, 1'b1, LW*FH);
    idle(6, 1'b0);
    check("gapped_200_count", cnt200, 2*(FH-2));

    // iSOF pulse during row 3, then a full new frame
    send_frame(1, 0, 1'b1, 3*LW + 3);
    idle(1, 1'b1);
    cnt200 = 0;
    send_frame(1, 0, 1'b0, LW*FH);
    idle(6, 1'b0);
    check("sof_mid_200_count", cnt200, 2*(FH-2));

    // random frames: with iSOF, with natural row wrap, and with iSOF again
    send_frame(3, 2, 1'b1, LW*FH);
    send_frame(3, 2, 1'b0, LW*FH);
    send_frame(3, 0, 1'b1, LW*FH);
    idle(6, 1'b0);

    // reset asserted between clock edges in the middle of a frame
    send_frame(3, 0, 1'b1, 20);
    #2;
    check("pre_reset_dval", int'(dval_s2), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_dval", int'({dval_s2, dval_s0}), 0);
    check("async_reset_edge", int'({edge_s2, edge_s0}), 0);
    flush_model();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      gray = 8'($urandom_range(0, 255));
      dval = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dval = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // after reset, the first pixel is (0,0) without iSOF
    send_frame(3, 1, 1'b0, LW*FH);
    send_frame(1, 0, 1'b1, LW*FH);
    idle(8, 1'b0);

    check("queue_empty", due_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
